// File: rtl/adlv_err_rec.sv
// Error-recovery stage: folds the deferred carries of the approximate adder back
// into the sum one position per clock, yielding the exact W+1-bit result.
module adlv_err_rec #(
  parameter int W        = 31,
  parameter int MAX_ITER = 32,
  parameter int CW       = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  s_in,
  input  logic [W-1:0]  e_in,
  input  logic          i_approx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    o_sum,
  output logic          o_inexact,
  output logic          o_ovf,
  output logic [CW-1:0] o_iter
);

  typedef enum logic [1:0] {IDLE, RESOLVE, DONE} state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ITER);

  state_t        state_q, state_d;
  logic [W:0]    sum_q, sum_d;
  logic [W:0]    car_q, car_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          apx_q, apx_d;
  logic [W:0]    osum_q, osum_d;
  logic [CW-1:0] oiter_q, oiter_d;
  logic          oovf_q, oovf_d;
  logic          oinex_q, oinex_d;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    car_d   = car_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    apx_d   = apx_q;
    osum_d  = osum_q;
    oiter_d = oiter_q;
    oovf_d  = oovf_q;
    oinex_d = oinex_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sum_d   = {1'b0, s_in};
          car_d   = {e_in, 1'b0};
          cnt_d   = '0;
          ovf_d   = 1'b0;
          apx_d   = i_approx;
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        if (apx_q || (car_q == '0) || (cnt_q == MAX_CNT)) begin
          osum_d  = sum_q;
          oiter_d = cnt_q;
          oovf_d  = ovf_q;
          // Only a capped run with carries left over is inexact; bypass never is.
          oinex_d = !(apx_q || (car_q == '0));
          state_d = DONE;
        end else begin
          sum_d = sum_q ^ car_q;
          car_d = (sum_q & car_q) << 1;
          ovf_d = ovf_q | (sum_q[W] & car_q[W]);
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      car_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      apx_q   <= 1'b0;
      osum_q  <= '0;
      oiter_q <= '0;
      oovf_q  <= 1'b0;
      oinex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      car_q   <= car_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      apx_q   <= apx_d;
      osum_q  <= osum_d;
      oiter_q <= oiter_d;
      oovf_q  <= oovf_d;
      oinex_q <= oinex_d;
    end
  end

  // Gate with rst_n so the block never advertises readiness while held in reset.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign o_sum     = osum_q;
  assign o_iter    = oiter_q;
  assign o_ovf     = oovf_q;
  assign o_inexact = oinex_q;

endmodule
